// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default widths, reset PC and the {instr, pc} beat
// handed from fetch to decode.
package fetch_pkg;

  localparam int unsigned PC_W     = 12;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned RESET_PC = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_beat_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO holding fetch beats for decode; flush empties it in one edge
// and takes priority over any push or pop in the same cycle.
module fetch_skid_fifo #(
  parameter type beat_t = logic [31:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  beat_t      push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output beat_t      head_o,
  output logic       head_valid_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic       do_pop;

  assign do_pop       = pop_i && (count_q != 2'd0);
  assign head_o       = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;

  // Storage is cleared on reset so the head outputs read as zero until the first beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one aligned address per cycle to a
// memory with one-cycle read latency, and streams {instr, pc} beats to decode.
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(fetch_pkg::RESET_PC)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [fetch_pkg::INSTR_W-1:0] imem_rdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         if_valid,
  input  logic                         if_ready,
  output logic [fetch_pkg::INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]              if_pc
);

  import fetch_pkg::*;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } beat_t;

  localparam logic [PC_W-1:0] ALIGN_MASK   = ~PC_W'(3);
  localparam logic [PC_W-1:0] RESET_PC_ALN = RESET_PC & ALIGN_MASK;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            drop_q;
  logic [1:0]      fifo_count;
  logic [2:0]      credit_used;
  logic            pop, push, issue;
  beat_t           push_beat, head_beat;

  assign imem_addr = pc_q;
  assign pop       = if_valid & if_ready;

  // Buffered plus outstanding beats, less the one leaving now, must leave room for one more.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = !redirect_valid && (credit_used < 3'd2);

  assign push            = inflight_q && !drop_q && !redirect_valid;
  assign push_beat.instr = imem_rdata;
  assign push_beat.pc    = inflight_pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (issue) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_ALN;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      // A redirect never issues, so any read still returning afterwards is stale.
      drop_q <= redirect_valid & inflight_q;
    end
  end

  fetch_skid_fifo #(
    .beat_t(beat_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_beat),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head_beat),
    .head_valid_o(if_valid),
    .count_o     (fifo_count)
  );

  assign if_instr = head_beat.instr;
  assign if_pc    = head_beat.pc;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch initiator that drives the byte-addressed instruction memory. Owns the program counter and issues one word-aligned address per cycle. Accounts for the memory's one-cycle registered read latency and delivers {instruction, PC} beats to decode over a valid/ready handshake. Supports redirects (branch/jump) that flush all in-flight and buffered fetches.

## Interface
- PC_W, 12: PC / instruction-memory byte-address width.
- RESET_PC, 0: PC value after reset; must be a multiple of 4.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  PC_W  byte address presented to instruction memory; memory samples it at the rising edge.
- imem_rdata  in  32  little-endian word {mem[a+3],mem[a+2],mem[a+1],mem[a]}; valid in the cycle after the edge that sampled address a.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  PC_W  new PC; bits [1:0] ignored (forced to 0).
- if_valid  out  1  beat available to decode.
- if_ready  in  1  decode accepts the beat.
- if_instr  out  32  instruction word of the head beat.
- if_pc  out  PC_W  byte address of if_instr.

## Operation
- State: pc_q (next address to issue), inflight_q plus inflight_pc_q (one outstanding read), drop_q (discard the outstanding read), 2-entry output FIFO.
- imem_addr = pc_q at all times.
- pop = if_valid & if_ready.
- issue = !redirect_valid & (fifo_count + inflight_q - pop < 2).
- On issue: pc_q <= pc_q + 4, modulo 2^PC_W (wraps to 0 above 2^PC_W-4); inflight_q <= 1; inflight_pc_q <= pc_q.
- Without issue: inflight_q <= 0.
- Return: if inflight_q & !drop_q, push {imem_rdata, inflight_pc_q} into the FIFO at the edge.
- Push and pop in the same cycle are both performed; FIFO order is preserved.
- The credit rule guarantees a push never finds the FIFO full. Overflow is a design error; the bench checks it with an assertion.
- Redirect (highest priority) takes effect at the edge:
  - FIFO cleared; if_valid low next cycle.
  - Any read in flight dropped (not pushed).
  - pc_q <= {redirect_pc[PC_W-1:2], 2'b00}; no issue this edge.
  - A pop in the same cycle still counts as accepted by decode.
- Back-to-back redirects: the last one wins; no fetch from the earlier target is ever delivered.

## Timing
- Reset values (while rst_n low at an edge): pc_q = RESET_PC, imem_addr = RESET_PC, inflight_q = 0, drop_q = 0, FIFO empty, if_valid = 0, if_instr = 0, if_pc = 0.
- E1 is the first edge with rst_n high.
  - E1 issues RESET_PC.
  - E2 pushes it.
  - if_valid = 1 with if_pc = RESET_PC after E2.
- Startup / redirect latency: 2 edges from issue-capable state to if_valid.
- Throughput: 1 beat/cycle sustained while if_ready stays high.
- if_ready low: at most 2 beats buffered plus 0 in flight. Issue resumes the cycle if_ready returns; no bubble at resume.
- Outputs if_instr/if_pc are held stable while if_valid & !if_ready.
- Reset asserted mid-operation clears everything at that edge regardless of other inputs.

## Structure
- Shared package fetch_pkg: PC_W, INSTR_W = 32, the fetch beat struct {instr, pc}, RESET_PC default.
- One sub-module: fetch_skid_fifo, 2-entry, parameterised on beat type. Provides push, pop, flush, count, and head outputs.
- The top holds the PC, credit logic and redirect/drop control.

## Test plan
- Reset release, if_ready = 1, memory preloaded with words at 0,4,8 -> if_valid after E2; beats pc 0,4,8 on consecutive cycles with matching words (e.g. 0x00500613 at 0).
- if_ready low for 5 cycles after the first beat -> exactly 2 beats buffered, imem_addr stalls at 12. On release, pc 4,8,12 appear with no gaps or duplicates.
- redirect_valid with redirect_pc = 0x02B (while one read is in flight and 1 beat is buffered) -> buffered and in-flight beats discarded; next delivered if_pc = 0x028, two edges after redirect.
- PC wrap: redirect to 0xFFC -> beats 0xFFC then 0x000.
- rst_n low for one edge mid-stream with if_ready toggling -> all outputs return to reset values; fetch restarts at RESET_PC.
- Random if_ready plus random redirects, 10k cycles, against a reference queue model -> in-order, no loss or duplication; FIFO-overflow assertion never fires.
